// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive FIFO sizing and the byte type.
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int UART_RX_FIFO_DEPTH     = 16;
  localparam int UART_RX_FIFO_THRESHOLD = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind uart_rx_path: first-word-fall-through read port,
// fill level, sticky overrun flag and a level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_RX_FIFO_DEPTH,
  parameter int THRESHOLD = UART_RX_FIFO_THRESHOLD,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rx_data_i,
  input  logic                   rx_done_i,
  input  logic                   rd_en_i,
  input  logic                   flush_i,
  input  logic                   clr_overrun_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [AW:0]            count_o,
  output logic                   overrun_o,
  output logic                   irq_o
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESHOLD);

  uart_byte_t    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overrun_reg, overrun_next;

  logic empty, full;
  logic do_write, do_pop, overrun_set;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

  // When full the FIFO is never empty, so rd_en_i alone guarantees a pop frees a slot.
  always_comb begin
    do_pop      = rd_en_i && !empty && !flush_i;
    do_write    = rx_done_i && !flush_i && (!full || rd_en_i);
    overrun_set = rx_done_i && full && !rd_en_i && !flush_i;
  end

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_set | (overrun_reg & ~clr_overrun_i);
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_write) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (do_pop)   rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({do_write, do_pop})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  // Storage is deliberately left out of reset; empty_o masks stale contents.
  always_ff @(posedge clk50) begin
    if (do_write) mem_reg[wr_ptr_reg] <= rx_data_i;
  end

  assign rd_data_o = empty ? '0 : mem_reg[rd_ptr_reg];
  assign empty_o   = empty;
  assign full_o    = full;
  assign count_o   = count_reg;
  assign overrun_o = overrun_reg;
  assign irq_o     = (count_reg >= THRESH_C) || overrun_reg;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESHOLD=8).
module tb_uart_rx_fifo;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_done_i = 1'b0;
  logic       rd_en_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       clr_overrun_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       empty_o, full_o, overrun_o, irq_o;
  logic [4:0] count_o;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo dut (
    .clk50(clk50), .reset(reset), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .rd_en_i(rd_en_i), .flush_i(flush_i), .clr_overrun_i(clr_overrun_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
    .overrun_o(overrun_o), .irq_o(irq_o)
  );

  always #10 clk50 = ~clk50;

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0;
    $display("push %02h -> count=%0d ovr=%0b", b, count_o, overrun_o);
  endtask

  task automatic pop();
    logic [7:0] seen;
    seen = rd_data_o;
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    $display("pop  %02h -> count=%0d", seen, count_o);
  endtask

  task automatic test_reset();
    #5;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if ({full_o, overrun_o, irq_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {full_o, overrun_o, irq_o}); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    push(8'h41);
    checks++; if (rd_data_o !== 8'h41 || empty_o !== 1'b0) begin errors++; $display("FAIL fd_first_visible: got %h/%b want 41/0", rd_data_o, empty_o); end
    push(8'h42);
    push(8'h43);
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL fd_count3: got %0d want 3", count_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data_o !== 8'(8'h41 + i)) begin errors++; $display("FAIL fd_data%0d: got %h want %h", i, rd_data_o, 8'(8'h41 + i)); end
      pop();
      checks++; if (count_o !== 5'(2 - i)) begin errors++; $display("FAIL fd_count_after_pop%0d: got %0d want %0d", i, count_o, 2 - i); end
    end
    checks++; if (empty_o !== 1'b1 || rd_data_o !== 8'h00) begin errors++; $display("FAIL fd_empty_end: got %b/%h want 1/00", empty_o, rd_data_o); end
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i <= 16; i++) push(8'(i));
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fo_full: got %b want 1", full_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fo_count: got %0d want 16", count_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL fo_overrun: got %b want 1", overrun_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL fo_irq: got %b want 1", irq_o); end
    // overrun set and clear in the same cycle: set must win
    rx_data_i = 8'h11; rx_done_i = 1'b1; clr_overrun_i = 1'b1;
    tick();
    rx_done_i = 1'b0; clr_overrun_i = 1'b0;
    checks++; if (overrun_o !== 1'b1 || count_o !== 5'd16) begin errors++; $display("FAIL fo_set_beats_clear: got ovr=%b cnt=%0d want 1/16", overrun_o, count_o); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data_o !== 8'(i)) begin errors++; $display("FAIL fo_drain%0d: got %h want %h", i, rd_data_o, 8'(i)); end
      pop();
    end
    checks++; if (empty_o !== 1'b1 || overrun_o !== 1'b1) begin errors++; $display("FAIL fo_after_drain: got empty=%b ovr=%b want 1/1", empty_o, overrun_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    checks++; if (count_o !== 5'd5) begin errors++; $display("FAIL fl_count5: got %0d want 5", count_o); end
    rx_data_i = 8'h55; rx_done_i = 1'b1; flush_i = 1'b1;
    tick();
    rx_done_i = 1'b0; flush_i = 1'b0;
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || rd_data_o !== 8'h00) begin errors++; $display("FAIL fl_flushed: got cnt=%0d empty=%b data=%h want 0/1/00", count_o, empty_o, rd_data_o); end
    checks++; if (overrun_o !== 1'b1 || irq_o !== 1'b1) begin errors++; $display("FAIL fl_keeps_overrun: got ovr=%b irq=%b want 1/1", overrun_o, irq_o); end
    pop();
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || rd_data_o !== 8'h00) begin errors++; $display("FAIL fl_pop_empty: got cnt=%0d empty=%b full=%b data=%h want 0/1/0/00", count_o, empty_o, full_o, rd_data_o); end
    clr_overrun_i = 1'b1;
    tick();
    clr_overrun_i = 1'b0;
    checks++; if (overrun_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL fl_clear_overrun: got ovr=%b irq=%b want 0/0", overrun_o, irq_o); end
    push(8'h66);
    checks++; if (rd_data_o !== 8'h66 || count_o !== 5'd1) begin errors++; $display("FAIL fl_after_flush: got %h cnt=%0d want 66/1", rd_data_o, count_o); end
    pop();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fs_full: got %b want 1", full_o); end
    checks++; if (rd_data_o !== 8'h80) begin errors++; $display("FAIL fs_head: got %h want 80", rd_data_o); end
    rx_data_i = 8'hAA; rx_done_i = 1'b1; rd_en_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rd_en_i = 1'b0;
    checks++; if (count_o !== 5'd16 || overrun_o !== 1'b0 || full_o !== 1'b1) begin errors++; $display("FAIL fs_simul: got cnt=%0d ovr=%b full=%b want 16/0/1", count_o, overrun_o, full_o); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (rd_data_o !== 8'(8'h80 + i)) begin errors++; $display("FAIL fs_drain%0d: got %h want %h", i, rd_data_o, 8'(8'h80 + i)); end
      pop();
    end
    checks++; if (rd_data_o !== 8'hAA) begin errors++; $display("FAIL fs_last: got %h want aa", rd_data_o); end
    pop();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fs_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_threshold_wrap();
    logic [7:0] q[$];
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      b = 8'(8'h20 + i); push(b); q.push_back(b);
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL tw_irq_low%0d: got %b want 0 at cnt=%0d", i, irq_o, count_o); end
    end
    b = 8'h27; push(b); q.push_back(b);
    checks++; if (irq_o !== 1'b1 || count_o !== 5'd8) begin errors++; $display("FAIL tw_irq_at8: got irq=%b cnt=%0d want 1/8", irq_o, count_o); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (rd_data_o !== q[0]) begin errors++; $display("FAIL tw_data%0d: got %h want %h", i, rd_data_o, q[0]); end
      void'(q.pop_front());
      pop();
      checks++; if (irq_o !== 1'b0 || count_o !== 5'd7) begin errors++; $display("FAIL tw_drop%0d: got irq=%b cnt=%0d want 0/7", i, irq_o, count_o); end
      b = 8'(8'h28 + i); push(b); q.push_back(b);
      checks++; if (irq_o !== 1'b1 || count_o !== 5'd8) begin errors++; $display("FAIL tw_rise%0d: got irq=%b cnt=%0d want 1/8", i, irq_o, count_o); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data_o !== q[0]) begin errors++; $display("FAIL tw_tail%0d: got %h want %h", i, rd_data_o, q[0]); end
      void'(q.pop_front());
      pop();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL tw_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= 16; i++) push(8'(8'hC0 + i));
    for (int i = 0; i < 13; i++) pop();
    checks++; if (count_o !== 5'd3 || overrun_o !== 1'b1) begin errors++; $display("FAIL rm_setup: got cnt=%0d ovr=%b want 3/1", count_o, overrun_o); end
    @(negedge clk50);
    #2 reset = 1'b1;
    #1;
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || rd_data_o !== 8'h00) begin errors++; $display("FAIL rm_async: got cnt=%0d empty=%b data=%h want 0/1/00", count_o, empty_o, rd_data_o); end
    checks++; if ({full_o, overrun_o, irq_o} !== 3'b000) begin errors++; $display("FAIL rm_flags: got %b want 000", {full_o, overrun_o, irq_o}); end
    tick();
    reset = 1'b0;
    tick();
    push(8'h99);
    checks++; if (rd_data_o !== 8'h99 || count_o !== 5'd1) begin errors++; $display("FAIL rm_resume: got %h cnt=%0d want 99/1", rd_data_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_overrun();
    test_flush();
    test_full_simul();
    test_threshold_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of `uart_rx_path`. It captures each byte flagged by the one-cycle `uart_rx_done` pulse and holds up to `DEPTH` bytes for a slower consumer (CPU register port or the TX path). The consumer reads through a first-word-fall-through interface. The block also reports fill level, a sticky overrun flag and a level interrupt.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `THRESHOLD`, 8: `irq_o` level; 1 ≤ THRESHOLD ≤ DEPTH.
- `AW`, $clog2(DEPTH): pointer width; derived, not overridden.

- `clk50`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data_i`  in  8  byte from `uart_rx_path` (`uart_rx_data_o`).
- `rx_done_i`  in  1  one-cycle strobe: `rx_data_i` valid this cycle.
- `rd_en_i`  in  1  consumer pop request.
- `flush_i`  in  1  discard all stored bytes.
- `clr_overrun_i`  in  1  clear the sticky overrun flag.
- `rd_data_o`  out  8  head byte; 8'h00 while empty.
- `empty_o`  out  1  no bytes stored.
- `full_o`  out  1  DEPTH bytes stored.
- `count_o`  out  AW+1  bytes stored, 0..DEPTH.
- `overrun_o`  out  1  sticky: a byte was dropped.
- `irq_o`  out  1  `count_o >= THRESHOLD` or `overrun_o`.

## Operation
- Storage is a DEPTH×8 register array with AW-bit write and read pointers. Pointers wrap modulo DEPTH. `count_o` is a separate AW+1-bit register, not derived from the pointers.
- **Write:** on a rising edge with `rx_done_i`=1, store `rx_data_i` at `wr_ptr`, then increment `wr_ptr`. Accepted only if not full, or if a pop happens in the same cycle.
- **Pop:** on a rising edge with `rd_en_i`=1 and not empty, increment `rd_ptr`. `rd_en_i` while empty is ignored; no pointer or flag changes.
- **Simultaneous write and pop:**
  - Not empty: both take effect and `count_o` is unchanged. This includes the full case, where no overrun occurs.
  - Empty: only the write takes effect.
- **Overrun:** a write strobe while full with no pop drops the byte and sets `overrun_o`. Stored data is untouched.
  - `overrun_o` stays set until `clr_overrun_i`.
  - If a set and a clear occur in the same cycle, the set wins.
- **Flush:** `flush_i`=1 resets both pointers and `count_o` to 0 on that edge. It has priority over a write or pop in the same cycle; a same-cycle byte is discarded and overrun is not set. Flush does not clear `overrun_o`.
- **Flags:** `empty_o`, `full_o` and `irq_o` are decoded combinationally from the registered `count_o` and `overrun_o`.
- **Read data:** `rd_data_o = empty_o ? 8'h00 : mem[rd_ptr]` (combinational read).
- **Reset:** pointers, `count_o`, `overrun_o` = 0. This gives `empty_o`=1, `full_o`=0, `irq_o`=0, `rd_data_o`=8'h00. Array contents are not reset.
- No internal state machine beyond the pointer/count registers. Occupancy states are EMPTY, PARTIAL and FULL, as implied by `count_o`.

## Timing
- Write to visible: byte strobed at edge N appears on `rd_data_o` with `empty_o`=0 after edge N (one-cycle latency).
- Pop: consumer samples `rd_data_o` while asserting `rd_en_i`. The next byte (or 8'h00 and `empty_o`) is presented after that edge.
- Back-to-back pops on consecutive cycles are allowed, one byte per cycle.
- `rx_done_i` arrives at most once per UART frame; the block still accepts a strobe every cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). Reset deassertion is synchronized externally.
- No combinational path from `rd_en_i` or `rx_done_i` to any output.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8
  - `UART_RX_FIFO_DEPTH` = 16
  - `UART_RX_FIFO_THRESHOLD` = 8
  - byte typedef `uart_byte_t`
- Single module; no sub-module is warranted. Storage, pointers and flags total about 150 lines.

## Test plan
- **Fill and drain:** after reset check `empty_o`=1 and `rd_data_o`=8'h00. Strobe 8'h41, 8'h42, 8'h43, then pop three times. Expect 41, 42, 43 in order; `count_o` goes 3→0; `empty_o` returns to 1.
- **Full and overrun:** strobe 17 bytes 8'h00..8'h10 with DEPTH=16 and no pops. Expect `full_o`=1, `count_o`=16, `overrun_o`=1, `irq_o`=1. Draining yields 8'h00..8'h0F; 8'h10 is lost.
- **Simultaneous write and pop when full:** with the FIFO full, strobe 8'hAA together with `rd_en_i`. Expect `count_o` to stay 16 and `overrun_o` to stay 0; 8'hAA is read last.
- **Threshold and wrap:** perform 40 single write/pop pairs so the pointers wrap. Data stays in order. `irq_o` asserts exactly when `count_o` reaches 8 and drops at 7.
- **Flush priority and pop on empty:** with 5 bytes stored, assert `flush_i` together with a strobe of 8'h55. Expect `count_o`=0, `empty_o`=1 and 8'h55 absent. A following `rd_en_i` on the empty FIFO leaves all outputs unchanged.
- **Reset mid-stream:** assert `reset` asynchronously with 3 bytes stored and `overrun_o`=1. All outputs return to their reset values before the next clock edge.
